// File: rtl/rfid_pkg.sv
// rfid_pkg: PIE FSM encodings and CRC-16 constants shared by the Gen2 TX encoder and RX detector/decoder.
package rfid_pkg;
    typedef enum logic [2:0] {
        PIE_IDLE, PIE_DELIM, PIE_DATA0, PIE_RTCAL, PIE_TRCAL, PIE_BITS, PIE_CRC
    } pie_state_t;
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC-16 (poly 0x1021, preset 0xFFFF), MSB-first remainder update.
module crc16_serial
    import rfid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] rem
);
    always_ff @(posedge clk) begin
        if (rst || clear) rem <= CRC16_PRESET;
        else if (bit_en) rem <= {rem[14:0], 1'b0} ^ ((rem[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
    end
endmodule

// File: rtl/pie_encoder.sv
// pie_encoder: EPC Gen2 reader-to-tag PIE envelope encoder (preamble/frame-sync, command bits).
// Define PIE_CRC16_EN to allow appending the ones-complement CRC-16 when crc_en is set at start.
module pie_encoder
    import rfid_pkg::*;
#(
    parameter int TARI  = 16,
    parameter int PW    = 8,
    parameter int DELIM = 12,
    parameter int RTCAL = 44,
    parameter int TRCAL = 88
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic preamble_sel,
    input  logic crc_en,
    input  logic in_dat,
    input  logic in_vld,
    input  logic in_last,
    output logic in_rdy,
    output logic out_dat,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int CNT_W = $clog2(TRCAL + 1);
    localparam logic [CNT_W-1:0] L_D0 = CNT_W'(TARI);
    localparam logic [CNT_W-1:0] L_D1 = CNT_W'(2 * TARI);
    localparam logic [CNT_W-1:0] L_RT = CNT_W'(RTCAL);
    localparam logic [CNT_W-1:0] L_TR = CNT_W'(TRCAL);
    localparam logic [CNT_W-1:0] L_PW = CNT_W'(PW);
    localparam logic [CNT_W-1:0] L_DL = CNT_W'(DELIM - 1);
    pie_state_t st;
    logic [CNT_W-1:0] cnt, len, cnt_nx;
    logic pre, bit_last, fetch_sym, sym_end;
    assign cnt_nx    = cnt + 1'b1;
    assign sym_end   = cnt == len - 1'b1;
    // symbols whose last cycle pulls the next command bit
    assign fetch_sym = (st == PIE_RTCAL && !pre) || st == PIE_TRCAL || (st == PIE_BITS && !bit_last);
`ifdef PIE_CRC16_EN
    logic crc_on;
    logic [15:0] crc_rem, crc_sh;
    logic [3:0] crc_idx;
    crc16_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (st == PIE_IDLE && start),
        .bit_en (in_rdy && in_vld),
        .bit_in (in_dat),
        .rem    (crc_rem)
    );
`else
    logic unused_crc_en;
    assign unused_crc_en = crc_en;
`endif
    always_ff @(posedge clk) begin
        done <= 1'b0;
        err  <= 1'b0;
        if (rst) begin
            st       <= PIE_IDLE;
            cnt      <= '0;
            len      <= '0;
            pre      <= 1'b0;
            bit_last <= 1'b0;
            out_dat  <= 1'b1;
            in_rdy   <= 1'b0;
            busy     <= 1'b0;
        end else if (st == PIE_IDLE) begin
            if (start) begin
                st      <= PIE_DELIM;
                cnt     <= '0;
                pre     <= preamble_sel;
                busy    <= 1'b1;
                out_dat <= 1'b0;
`ifdef PIE_CRC16_EN
                crc_on  <= crc_en;
`endif
            end
        end else if (st == PIE_DELIM) begin
            if (cnt == L_DL) begin
                st      <= PIE_DATA0;
                cnt     <= '0;
                len     <= L_D0;
                out_dat <= 1'b1;
            end else cnt <= cnt_nx;
        end else if (!sym_end) begin
            cnt     <= cnt_nx;
            out_dat <= cnt_nx < len - L_PW;
            in_rdy  <= fetch_sym && cnt_nx == len - 1'b1;
        end else begin
            cnt     <= '0;
            out_dat <= 1'b1;
            in_rdy  <= 1'b0;
            if (st == PIE_DATA0) begin
                st  <= PIE_RTCAL;
                len <= L_RT;
            end else if (st == PIE_RTCAL && pre) begin
                st  <= PIE_TRCAL;
                len <= L_TR;
            end else if (fetch_sym) begin
                if (in_vld) begin
                    st       <= PIE_BITS;
                    len      <= in_dat ? L_D1 : L_D0;
                    bit_last <= in_last;
                end else begin
                    st   <= PIE_IDLE;
                    busy <= 1'b0;
                    err  <= 1'b1;
                end
            end
`ifdef PIE_CRC16_EN
            // remainder is sent inverted, MSB first
            else if (st == PIE_BITS && crc_on) begin
                st      <= PIE_CRC;
                len     <= crc_rem[15] ? L_D0 : L_D1;
                crc_sh  <= {~crc_rem[14:0], 1'b0};
                crc_idx <= 4'd0;
            end else if (st == PIE_CRC && crc_idx != 4'd15) begin
                len     <= crc_sh[15] ? L_D1 : L_D0;
                crc_sh  <= {crc_sh[14:0], 1'b0};
                crc_idx <= crc_idx + 1'b1;
            end
`endif
            else begin
                st   <= PIE_IDLE;
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pie_encoder.sv
// tb_pie_encoder: directed checks of PIE framing, fetch timing, underrun, reset abort and optional CRC.
module tb_pie_encoder;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, preamble_sel = 1'b0, crc_en = 1'b0;
    logic in_dat = 1'b0, in_vld = 1'b0, in_last = 1'b0;
    logic in_rdy, out_dat, busy, done, err;
    int n_chk = 0, n_fail = 0;
    logic [4:0] rec [0:8191];
    bit cmd[$];
    bit exp_out[$];

    always #5 clk = ~clk;

    pie_encoder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .preamble_sel (preamble_sel),
        .crc_en       (crc_en),
        .in_dat       (in_dat),
        .in_vld       (in_vld),
        .in_last      (in_last),
        .in_rdy       (in_rdy),
        .out_dat      (out_dat),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sym(input int l);
        repeat (l - 8) exp_out.push_back(1'b1);
        repeat (8) exp_out.push_back(1'b0);
    endtask

    task automatic build(input bit pre, input int ncrc, input logic [15:0] crc);
        exp_out.delete();
        repeat (12) exp_out.push_back(1'b0);
        sym(16);
        sym(44);
        if (pre) sym(88);
        foreach (cmd[i]) sym(cmd[i] ? 32 : 16);
        for (int i = 15; i >= 16 - ncrc; i--) sym(crc[i] ? 32 : 16);
    endtask

    // rec[k] = {err, in_rdy, done, busy, out_dat} in the k-th cycle after the start edge
    task automatic run(input bit pre, input bit ce, input int ncyc, input int und, input int sp_at, input int rst_at);
        int idx = 0, fetch = 0;
        bit take = 1'b0;
        @(negedge clk);
        preamble_sel = pre;
        crc_en = ce;
        start = 1'b1;
        in_vld = 1'b1;
        in_dat = cmd[0];
        in_last = cmd.size() == 1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = (k == sp_at);
            rst = (k == rst_at);
            if (take) idx++;
            rec[k] = {err, in_rdy, done, busy, out_dat};
            if (in_rdy) fetch++;
            in_dat = idx < cmd.size() ? cmd[idx] : 1'b0;
            in_last = idx >= cmd.size() - 1;
            in_vld = !(in_rdy && fetch == und);
            take = in_rdy && in_vld;
        end
        start = 1'b0;
        rst = 1'b0;
        in_vld = 1'b0;
    endtask

    function automatic int first_hi(input int sel, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (rec[k][sel]) return k;
        return -1;
    endfunction

    function automatic int cnt_hi(input int sel, input int lo, input int hi);
        int n = 0;
        for (int k = lo; k <= hi; k++) n += int'(rec[k][sel]);
        return n;
    endfunction

    function automatic int wave_bad(input int off);
        int b = 0;
        for (int k = 1; k <= exp_out.size(); k++) if (rec[off + k][0] != exp_out[k - 1]) b++;
        return b + (rec[off + exp_out.size() + 1][0] ? 0 : 1);
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({err, in_rdy, done, busy, out_dat}), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outputs", int'({err, in_rdy, done, busy, out_dat}), 1);

        cmd = '{1'b1, 1'b0};
        build(1'b1, 0, 16'h0);
        run(1'b1, 1'b0, 260, 0, 0, 0);
        check("t1_len", exp_out.size(), 208);
        check("t1_wave_bad", wave_bad(0), 0);
        check("t1_first_low", int'(rec[1][1:0]), 2);
        check("t1_done_at", first_hi(2, 1, 260), 209);
        check("t1_done_cnt", cnt_hi(2, 1, 260), 1);
        check("t1_busy_208", int'(rec[208][1]), 1);
        check("t1_busy_209", int'(rec[209][1]), 0);
        check("t1_rdy_first", first_hi(3, 1, 260), 160);
        check("t1_rdy_cnt", cnt_hi(3, 1, 260), 2);
        check("t1_rdy_192", int'(rec[192][3]), 1);
        check("t1_err_cnt", cnt_hi(4, 1, 260), 0);

        cmd = '{1'b0};
        build(1'b0, 0, 16'h0);
        run(1'b0, 1'b0, 200, 0, 89, 0);
        check("t2_wave_bad", wave_bad(0), 0);
        check("t2_done_at", first_hi(2, 1, 89), 89);
        check("t2_rdy_at", first_hi(3, 1, 89), 72);
        check("t2_rdy_cnt", cnt_hi(3, 1, 89), 1);
        check("b2b_gap_cw", int'(rec[89][0]), 1);
        check("b2b_start", int'(rec[90][1:0]), 2);
        check("b2b_wave_bad", wave_bad(89), 0);
        check("b2b_done_at", first_hi(2, 90, 200), 178);
        check("b2b_done_cnt", cnt_hi(2, 1, 200), 2);

        cmd = '{1'b1, 1'b0};
        run(1'b1, 1'b0, 260, 2, 0, 0);
        check("t3_err_at", first_hi(4, 1, 260), 193);
        check("t3_err_cnt", cnt_hi(4, 1, 260), 1);
        check("t3_out_high", cnt_hi(0, 193, 260), 68);
        check("t3_busy_193", int'(rec[193][1]), 0);
        check("t3_done_cnt", cnt_hi(2, 1, 260), 0);

        run(1'b1, 1'b0, 200, 0, 0, 154);
        check("t4_pre_rst_low", int'(rec[154][0]), 0);
        check("t4_post_rst", int'(rec[155]), 1);
        check("t4_done_cnt", cnt_hi(2, 1, 200), 0);
        check("t4_err_cnt", cnt_hi(4, 1, 200), 0);
        cmd = '{1'b0};
        build(1'b0, 0, 16'h0);
        run(1'b0, 1'b0, 120, 0, 0, 0);
        check("t4_restart_wave", wave_bad(0), 0);
        check("t4_restart_done", first_hi(2, 1, 120), 89);

        cmd = '{1'b1, 1'b0};
        build(1'b1, 0, 16'h0);
        run(1'b1, 1'b0, 300, 0, 50, 0);
        check("t5_wave_bad", wave_bad(0), 0);
        check("t5_done_cnt", cnt_hi(2, 1, 300), 1);
        check("t5_busy_after", cnt_hi(1, 210, 300), 0);

`ifdef PIE_CRC16_EN
        begin
            string s = "123456789";
            byte ch;
            cmd.delete();
            for (int i = 0; i < s.len(); i++) begin
                ch = s[i];
                for (int b = 7; b >= 0; b--) cmd.push_back(ch[b]);
            end
            build(1'b0, 16, 16'hD64E);
            run(1'b0, 1'b1, exp_out.size() + 20, 0, 0, 0);
            check("t6_wave_bad", wave_bad(0), 0);
            check("t6_done_at", first_hi(2, 1, exp_out.size() + 20), exp_out.size() + 1);
            check("t6_rdy_cnt", cnt_hi(3, 1, exp_out.size() + 20), 72);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
